// File: rtl/sw_out_arbiter_pkg.sv
// Shared constants for the per-output switch allocator: VC field width,
// FSM state encoding, default credit depth and router port indices.
package sw_out_arbiter_pkg;

  localparam int VC_W              = 3;  // width of each req_vc field
  localparam int SEL_W             = 3;  // width of a port index / crossbar select
  localparam int DEFAULT_BUF_DEPTH = 4;  // flit slots per downstream VC buffer

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum int {
    PORT_LOCAL = 0,
    PORT_NORTH = 1,
    PORT_EAST  = 2,
    PORT_SOUTH = 3,
    PORT_WEST  = 4
  } port_id_t;

  // Next port index after idx, wrapping modulo n.
  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] idx, input int n);
    return (idx == SEL_W'(n - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/vc_credit_cnt.sv
// Credit counter for one downstream VC buffer. Starts full (BUF_DEPTH),
// decrements when a flit is sent, increments on a returned credit and
// saturates at BUF_DEPTH. With SW_OUT_ARB_CREDIT_ERR_EN defined it also
// flags a credit that arrives while the counter is already full.
module vc_credit_cnt
  import sw_out_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_W     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Net change of the count; simultaneous inc and dec cancel out.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec && (count_reg != FULL)) begin
      count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Counter register, reset to a full buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= FULL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count   = count_reg;
  assign nonzero = |count_reg;

`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  assign overflow = inc && (count_reg == FULL);
`endif

endmodule

// File: rtl/sw_out_arbiter.sv
// Per-output-port switch allocator. Round-robin among head flits while idle,
// then holds the port for the winning packet until its tail flit. No flit is
// granted toward a downstream VC with zero credits. Grant is combinational.
// Optional: SW_OUT_ARB_CREDIT_ERR_EN adds a sticky credit_err output.
module sw_out_arbiter
  import sw_out_arbiter_pkg::*;
#(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_W     = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PORT_NUM-1:0]      req,
  input  logic [VC_W*PORT_NUM-1:0] req_vc,
  input  logic [PORT_NUM-1:0]      req_head,
  input  logic [PORT_NUM-1:0]      req_tail,
  input  logic [VC_NUM-1:0]        credit_in,
  output logic [PORT_NUM-1:0]      grant,
  output logic                     grant_valid,
  output logic [SEL_W-1:0]         sel,
  output logic                     locked
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  ,
  output logic                     credit_err
`endif
);

  arb_state_t       state_reg, state_next;
  logic [SEL_W-1:0] owner_reg, owner_next;
  logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;

  logic [VC_W-1:0]   vc_of [PORT_NUM];
  logic [PORT_NUM-1:0] eligible;
  logic [VC_NUM-1:0] nonzero_vc;
  logic [7:0]        nonzero_all;   // padded so any 3-bit VC field indexes safely
  logic [VC_NUM-1:0] dec_vc;
  logic [CNT_W-1:0]  cnt [VC_NUM];
  logic [SEL_W-1:0]  grant_idx;
  logic              found;
  logic [VC_W-1:0]   grant_vc;
  logic              grant_tail;

  genvar gi;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_nz
      if (gi < VC_NUM) begin : g_real
        assign nonzero_all[gi] = nonzero_vc[gi];
      end else begin : g_pad
        assign nonzero_all[gi] = 1'b0;
      end
    end

    // A request qualifies only with a legal VC, a free downstream slot and
    // either a head flit (idle) or the lock owner's identity (locked).
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_elig
      assign vc_of[gi]    = req_vc[VC_W*gi +: VC_W];
      assign eligible[gi] = req[gi]
                         && (int'(vc_of[gi]) < VC_NUM)
                         && nonzero_all[vc_of[gi]]
                         && ((state_reg == IDLE) ? req_head[gi]
                                                 : (owner_reg == SEL_W'(gi)));
    end
  endgenerate

  // Round-robin search from rr_ptr; while locked only the owner can qualify.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < PORT_NUM; off++) begin
      sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(off);
      if (sum >= (SEL_W+1)'(PORT_NUM)) begin
        sum = sum - (SEL_W+1)'(PORT_NUM);
      end
      cand = sum[SEL_W-1:0];
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_valid = found;
  assign grant       = found ? (PORT_NUM'(1) << grant_idx) : '0;
  assign sel         = found ? grant_idx : '0;
  assign grant_vc    = vc_of[grant_idx];
  assign grant_tail  = req_tail[grant_idx];
  assign locked      = (state_reg == LOCKED);

  // Packet-lock transitions, taken only on a granted flit.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      case (state_reg)
        IDLE: begin
          rr_ptr_next = next_port(grant_idx, PORT_NUM);
          if (!grant_tail) begin
            state_next = LOCKED;
            owner_next = grant_idx;
          end
        end
        LOCKED: begin
          if (grant_tail) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Arbiter state registers; reset drops any held lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= SEL_W'(PORT_LOCAL);
      rr_ptr_reg <= SEL_W'(PORT_LOCAL);
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  logic [VC_NUM-1:0] overflow_vc;
  logic              credit_err_reg;
`endif

  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      assign dec_vc[gi] = grant_valid && (grant_vc == VC_W'(gi));

      vc_credit_cnt #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
      ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (credit_in[gi]),
        .dec      (dec_vc[gi]),
        .count    (cnt[gi]),
        .nonzero  (nonzero_vc[gi])
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
        ,
        .overflow (overflow_vc[gi])
`endif
      );

      // A credit count can never exceed the downstream buffer depth.
      assert property (@(posedge clock) disable iff (reset) cnt[gi] <= CNT_W'(BUF_DEPTH));
    end
  endgenerate

`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_err_reg <= 1'b0;
    end else if (|overflow_vc) begin
      credit_err_reg <= 1'b1;
    end
  end

  assign credit_err = credit_err_reg;
`endif

endmodule

// File: tb/tb_sw_out_arbiter.sv
// Testbench for sw_out_arbiter: a vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_sw_out_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  req, req_head, req_tail;
  logic [14:0] req_vc;
  logic [3:0]  credit_in;
  logic [4:0]  grant;
  logic        grant_valid;
  logic [2:0]  sel;
  logic        locked;
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
  logic        credit_err;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit         locked_m;
  int         owner_m, rr_m, m_pick;
  int         cnt_m [4];
  bit         err_m;
  logic [4:0] m_grant;
  logic [2:0] m_sel;

  typedef struct {
    logic [4:0]  r;
    logic [14:0] v;
    logic [4:0]  h;
    logic [4:0]  t;
    logic [3:0]  c;
    logic [4:0]  eg;
    logic [2:0]  es;
    logic        el;
  } vec_t;
  vec_t vecs [8];

  sw_out_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_vc      (req_vc),
    .req_head    (req_head),
    .req_tail    (req_tail),
    .credit_in   (credit_in),
    .grant       (grant),
    .grant_valid (grant_valid),
    .sel         (sel),
    .locked      (locked)
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
    ,
    .credit_err  (credit_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    locked_m = 0; owner_m = 0; rr_m = 0; err_m = 0;
    for (int v = 0; v < 4; v++) cnt_m[v] = 4;
  endtask

  // Expected grant from the arbitration rules applied to the present inputs.
  task automatic model_eval();
    m_pick = -1;
    for (int off = 0; off < 5; off++) begin
      int p;
      int v;
      p = (rr_m + off) % 5;
      v = int'(req_vc[3*p +: 3]);
      if (m_pick < 0 && req[p] && v < 4) begin
        if (cnt_m[v] > 0 && (locked_m ? (p == owner_m) : (req_head[p] == 1'b1))) m_pick = p;
      end
    end
    m_grant = '0;
    m_sel   = '0;
    if (m_pick >= 0) begin
      m_grant[m_pick] = 1'b1;
      m_sel = 3'(m_pick);
    end
  endtask

  // State changes at the clock edge, from the inputs held across it.
  task automatic model_commit();
    int decv [4];
    for (int v = 0; v < 4; v++) decv[v] = 0;
    if (m_pick >= 0) begin
      decv[int'(req_vc[3*m_pick +: 3])] = 1;
      if (!locked_m) begin
        rr_m = (m_pick + 1) % 5;
        if (!req_tail[m_pick]) begin
          locked_m = 1;
          owner_m  = m_pick;
        end
      end else if (req_tail[m_pick]) begin
        locked_m = 0;
      end
    end
    for (int v = 0; v < 4; v++) begin
      int n;
      if (credit_in[v] && cnt_m[v] == 4) err_m = 1;
      n = cnt_m[v] - decv[v] + (credit_in[v] ? 1 : 0);
      if (n > 4) n = 4;
      cnt_m[v] = n;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; req_vc = '0; req_head = '0; req_tail = '0; credit_in = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Called at posedge+1: apply inputs and let the combinational outputs settle.
  task automatic run(input logic [4:0] r, input logic [14:0] v, input logic [4:0] h,
                     input logic [4:0] t, input logic [3:0] c);
    req = r; req_vc = v; req_head = h; req_tail = t; credit_in = c;
    #3;
    model_eval();
  endtask

  task automatic clk_edge();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic chk_out(input string name, input logic [4:0] eg, input logic [2:0] es, input logic el);
    chk({name, ".grant"},  32'(grant), 32'(eg));
    chk({name, ".gvalid"}, 32'(grant_valid), 32'(|eg));
    chk({name, ".sel"},    32'(sel), 32'(es));
    chk({name, ".locked"}, 32'(locked), 32'(el));
  endtask

  // One hand-checked cycle.
  task automatic hs(input string name, input logic [4:0] r, input logic [14:0] v, input logic [4:0] h,
                    input logic [4:0] t, input logic [3:0] c,
                    input logic [4:0] eg, input logic [2:0] es, input logic el);
    run(r, v, h, t, c);
    chk_out(name, eg, es, el);
    clk_edge();
  endtask

  initial begin
    // Ports 1 and 3 send single-flit packets on VC0 every cycle.
    vecs[0] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b00010, 3'd1, 1'b0};
    vecs[1] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b01000, 3'd3, 1'b0};
    vecs[2] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b00010, 3'd1, 1'b0};
    vecs[3] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b01000, 3'd3, 1'b0};
    vecs[4] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b00000, 3'd0, 1'b0};
    vecs[5] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0001, 5'b00000, 3'd0, 1'b0};
    vecs[6] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b00010, 3'd1, 1'b0};
    vecs[7] = '{5'b01010, 15'd0, 5'b01010, 5'b01010, 4'b0000, 5'b00000, 3'd0, 1'b0};

    // Reset state
    do_reset();
    run(5'b0, 15'd0, 5'b0, 5'b0, 4'b0);
    chk_out("reset", 5'b0, 3'd0, 1'b0);
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
    chk("reset.credit_err", 32'(credit_err), 32'd0);
`endif
    clk_edge();

    // Vector table: alternation and VC0 credit exhaustion
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].r, vecs[i].v, vecs[i].h, vecs[i].t, vecs[i].c);
      chk_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].es, vecs[i].el);
      clk_edge();
    end

    // Wormhole lock: port 2 head/body/tail on VC1 while port 0 keeps asking
    do_reset();
    hs("lk.pre",  5'b00010, 15'd0,      5'b00010, 5'b00010, 4'b0, 5'b00010, 3'd1, 1'b0);
    hs("lk.head", 5'b00101, 15'd1 << 6, 5'b00101, 5'b00000, 4'b0, 5'b00100, 3'd2, 1'b0);
    hs("lk.body", 5'b00101, 15'd1 << 6, 5'b00001, 5'b00000, 4'b0, 5'b00100, 3'd2, 1'b1);
    hs("lk.tail", 5'b00101, 15'd1 << 6, 5'b00001, 5'b00100, 4'b0, 5'b00100, 3'd2, 1'b1);
    hs("lk.next", 5'b00001, 15'd0,      5'b00001, 5'b00001, 4'b0, 5'b00001, 3'd0, 1'b0);

    // Owner stalls on zero credits and keeps the lock
    do_reset();
    hs("st.head", 5'b10000, 15'd2 << 12, 5'b10000, 5'b0, 4'b0, 5'b10000, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++)
      hs($sformatf("st.body%0d", i), 5'b10000, 15'd2 << 12, 5'b0, 5'b0, 4'b0, 5'b10000, 3'd4, 1'b1);
    hs("st.zero",   5'b10010, 15'd2 << 12, 5'b00010, 5'b0, 4'b0000, 5'b0, 3'd0, 1'b1);
    hs("st.cred",   5'b10000, 15'd2 << 12, 5'b00000, 5'b0, 4'b0100, 5'b0, 3'd0, 1'b1);
    hs("st.resume", 5'b10000, 15'd2 << 12, 5'b00000, 5'b0, 4'b0000, 5'b10000, 3'd4, 1'b1);
    hs("st.empty",  5'b10000, 15'd2 << 12, 5'b00000, 5'b0, 4'b0000, 5'b0, 3'd0, 1'b1);
    hs("st.cred2",  5'b10000, 15'd2 << 12, 5'b00000, 5'b10000, 4'b0100, 5'b0, 3'd0, 1'b1);
    hs("st.tail",   5'b10000, 15'd2 << 12, 5'b00000, 5'b10000, 4'b0000, 5'b10000, 3'd4, 1'b1);
    hs("st.idle",   5'b00010, 15'd0, 5'b00010, 5'b00010, 4'b0000, 5'b00010, 3'd1, 1'b0);

    // Credit arithmetic on VC3: cancel, saturation, overflow flag
    do_reset();
    hs("cr.g1", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b1, 3'd0, 1'b0);
    hs("cr.g2", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b1, 3'd0, 1'b0);
    hs("cr.both", 5'b1, 15'd3, 5'b1, 5'b1, 4'b1000, 5'b1, 3'd0, 1'b0);
    hs("cr.g3", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b1, 3'd0, 1'b0);
    hs("cr.g4", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b1, 3'd0, 1'b0);
    hs("cr.block", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      hs($sformatf("cr.ret%0d", i), 5'b0, 15'd0, 5'b0, 5'b0, 4'b1000, 5'b0, 3'd0, 1'b0);
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
    chk("cr.err_before", 32'(credit_err), 32'd0);
`endif
    hs("cr.over", 5'b0, 15'd0, 5'b0, 5'b0, 4'b1000, 5'b0, 3'd0, 1'b0);
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
    chk("cr.err_after", 32'(credit_err), 32'd1);
`endif
    for (int i = 0; i < 4; i++)
      hs($sformatf("cr.full%0d", i), 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b1, 3'd0, 1'b0);
    hs("cr.sat", 5'b1, 15'd3, 5'b1, 5'b1, 4'b0000, 5'b0, 3'd0, 1'b0);

    // Reset in the middle of a packet
    do_reset();
    hs("rm.head", 5'b00100, 15'd1 << 6, 5'b00100, 5'b0, 4'b0, 5'b00100, 3'd2, 1'b0);
    hs("rm.body", 5'b00100, 15'd1 << 6, 5'b00000, 5'b0, 4'b0, 5'b00100, 3'd2, 1'b1);
    do_reset();
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
    chk("rm.credit_err", 32'(credit_err), 32'd0);
`endif
    for (int i = 0; i < 4; i++)
      hs($sformatf("rm.p0_%0d", i), 5'b1, 15'd1, 5'b1, 5'b1, 4'b0, 5'b1, 3'd0, 1'b0);
    hs("rm.empty", 5'b1, 15'd1, 5'b1, 5'b1, 4'b0, 5'b0, 3'd0, 1'b0);

    // Illegal VC field is ignored without disturbing other ports
    do_reset();
    for (int i = 0; i < 3; i++)
      hs($sformatf("bv.mix%0d", i), 5'b01010, 15'd5 << 3, 5'b01010, 5'b01010, 4'b0, 5'b01000, 3'd3, 1'b0);
    hs("bv.alone", 5'b00010, 15'd5 << 3, 5'b00010, 5'b00010, 4'b0, 5'b0, 3'd0, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic [14:0] v;
      logic [3:0]  c;
      v = '0;
      for (int p = 0; p < 5; p++) v[3*p +: 3] = 3'($urandom_range(0, 5));
      for (int b = 0; b < 4; b++) c[b] = ($urandom_range(0, 3) == 0);
      run(5'($urandom), v, 5'($urandom), 5'($urandom), c);
      chk($sformatf("rnd%0d.grant", n), 32'(grant), 32'(m_grant));
      chk($sformatf("rnd%0d.sel", n), 32'(sel), 32'(m_sel));
      chk($sformatf("rnd%0d.gvalid", n), 32'(grant_valid), 32'(m_pick >= 0));
      chk($sformatf("rnd%0d.locked", n), 32'(locked), 32'(locked_m));
`ifdef SW_OUT_ARB_CREDIT_ERR_EN
      chk($sformatf("rnd%0d.credit_err", n), 32'(credit_err), 32'(err_m));
`endif
      clk_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_out_arbiter.md
Name: sw_out_arbiter

Overview:
- Per-output-port switch allocator for the mesh router.
- Shares one output port and its downstream link among PORT_NUM input ports, each presenting a flit selected by its VC priority logic.
- Wormhole packet lock: round-robin between packets, then the owner holds the port until its tail flit.
- Tracks downstream buffer credits per VC, so no flit is granted toward a full downstream VC buffer.
- Drives the crossbar select for its output.

Parameters:
- PORT_NUM, 5, number of requesting input ports (N/E/S/W/local).
- VC_NUM, 4, number of downstream VCs; must be at most 8.
- BUF_DEPTH, 4, flit slots per downstream VC buffer; this is the credit counter reset value.
- CNT_W, 3, credit counter width; must hold BUF_DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  PORT_NUM  bit i: input port i presents a flit for this output this cycle.
- req_vc  in  3*PORT_NUM  downstream VC field of port i's flit, bits [3i+2:3i].
- req_head  in  PORT_NUM  flit i is a head flit.
- req_tail  in  PORT_NUM  flit i is a tail flit; head and tail both set means a single-flit packet.
- credit_in  in  VC_NUM  one-cycle pulse per VC: the downstream router freed one slot.
- grant  out  PORT_NUM  one-hot; port i's flit crosses this cycle.
- grant_valid  out  1  OR of grant.
- sel  out  3  index of the granted port; 0 when grant_valid=0.
- locked  out  1  a packet currently owns the port.

Behaviour:
- Grant timing:
  - grant, grant_valid and sel are combinational from the inputs and registered state, so request-to-grant latency is 0.
  - All state updates on the rising clock edge of a cycle with grant_valid=1.
- Registered state:
  - state: IDLE or LOCKED.
  - owner: port index.
  - rr_ptr: port index.
  - cnt[v]: per-VC credit count.
- Eligibility of port i:
  - req[i]=1.
  - req_vc_i < VC_NUM; otherwise the request is ignored and never granted.
  - cnt[req_vc_i] > 0.
  - In IDLE: req_head[i]=1.
  - In LOCKED: i == owner. The head flag is ignored; a stray head flag from the owner is treated as a body flit.
- IDLE arbitration: grant the first eligible port searching rr_ptr, rr_ptr+1, … with wrap modulo PORT_NUM.
- LOCKED: grant the owner if eligible, else no grant. Other ports are not served, even with credits.
- Transitions, on a grant to port k:
  - IDLE and not tail: go to LOCKED, owner<=k, rr_ptr<=(k+1) mod PORT_NUM.
  - IDLE and tail (single flit): stay in IDLE, rr_ptr<=(k+1) mod PORT_NUM.
  - LOCKED and tail: go to IDLE; rr_ptr unchanged.
- Credits:
  - cnt[v]_next = cnt[v] − (grant to VC v) + credit_in[v].
  - A simultaneous decrement and increment leaves the count unchanged.
  - An increment at cnt=BUF_DEPTH saturates and is dropped.
  - cnt never decrements below 0; this is guaranteed by the eligibility rule.
- Zero credits while LOCKED: owner stalls and the lock is held, with no timeout.
- Reset:
  - state=IDLE, owner=0, rr_ptr=0, every cnt=BUF_DEPTH.
  - Outputs: grant=0, grant_valid=0, sel=0, locked=0.
  - A reset mid-packet drops the lock; the upstream flush is handled elsewhere.
- locked is 1 exactly while state=LOCKED (registered).

Optional Feature:
- Macro: SW_OUT_ARB_CREDIT_ERR_EN.
- When defined: adds output credit_err (1 bit), a sticky register.
  - Set on any credit_in[v] pulse while cnt[v]=BUF_DEPTH (credit overflow).
  - Cleared only by reset.
- When undefined: the port is absent and overflow credits are silently dropped.

Decomposition:
- Shared constants package/include:
  - VC field width (3).
  - State encoding (IDLE=1'b0, LOCKED=1'b1).
  - Default BUF_DEPTH.
  - Port index constants (LOCAL=0 … WEST=4).
- One natural sub-module: vc_credit_cnt.
  - Ports: clock, reset, inc, dec, count, nonzero.
  - Instantiated VC_NUM times.
  - Also hosts the overflow detect when SW_OUT_ARB_CREDIT_ERR_EN is defined.
- The round-robin search stays in the top module.

Test Plan:
- Reset, then ports 1 and 3 each send single-flit packets (head+tail) on VC0 every cycle → grants alternate 1,3,1,3; sel=1,3,1,3; cnt[0] reaches 0 after 4 grants and grants stop.
- Port 2 sends head (VC1), body, tail on consecutive cycles while port 0 requests head every cycle → grant port 2 for 3 cycles with locked=1 during body/tail; port 0 is granted in the cycle after the tail.
- With cnt[2]=0 (4 grants, no credit_in), owner port 4 holds a body flit on VC2 → no grant and locked stays 1; one credit_in[2] pulse → grant next cycle and cnt[2] returns to 0.
- Simultaneous grant on VC3 and credit_in[3] at cnt=2 → cnt stays 2; at cnt=4, credit_in[3] alone → cnt stays 4, and credit_err=1 if the macro is defined.
- Reset asserted mid-packet (state LOCKED, owner 2) → next cycle locked=0, all cnt=4, and a head from port 0 is granted immediately.
- req_vc=5 with VC_NUM=4 → that port is never granted, and other ports are unaffected.
